// File: rtl/spi_master_param_if.sv
// SPI bus between spi_master_param and its SPI_SLAVE-style peers.
interface spi_master_param_if #(
  parameter int unsigned NCS = 2
) ();
  logic [NCS-1:0] LOAD;
  logic           SCLK;
  logic           MOSI;
  logic           MISO;

  modport master (output LOAD, output SCLK, output MOSI, input MISO);
  modport slave  (input LOAD, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: M-bit frames, mode 0..3 and slave select chosen per frame.
// Define SPI_LSB_FIRST_EN to add the per-frame lsb_first input.
module spi_master_param #(
  parameter int unsigned M   = 9,
  parameter int unsigned DIV = 4,
  parameter int unsigned NCS = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  st,
  input  logic [M-1:0]          DI,
  input  logic [1:0]            mode,
  input  logic [2:0]            cs,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  spi_master_param_if.master    spi,
  output logic [M-1:0]          DO,
  output logic                  busy,
  output logic                  done,
  output logic                  ce_tact,
  output logic [7:0]            cb_bit
);

  typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} state_e;

  localparam int unsigned   CntW     = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [7:0]    LastEdge = 8'(2 * M - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [M-1:0]    sr_tx_q, sr_tx_d, sr_rx_q, sr_rx_d, do_q, do_d;
  logic [NCS-1:0]  load_q, load_d, load_dec;
  logic [7:0]      cb_q, cb_d;
  logic            cpha_q, cpha_d, lsb_q, lsb_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            lsb_in, leading, last_edge;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic tx_bit(input logic [M-1:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[M-1];
  endfunction

  function automatic logic [M-1:0] tx_shift(input logic [M-1:0] sr, input logic lsb);
    return lsb ? {1'b0, sr[M-1:1]} : {sr[M-2:0], 1'b0};
  endfunction

  function automatic logic [M-1:0] rx_shift(input logic [M-1:0] sr, input logic b,
                                            input logic lsb);
    return lsb ? {b, sr[M-1:1]} : {sr[M-2:0], b};
  endfunction

  // Out-of-range channel index leaves every select deasserted.
  always_comb begin
    load_dec = '1;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (cs == 3'(i)) load_dec[i] = 1'b0;
    end
  end

  assign ce_tact   = (state_q != StIdle) && (cnt_q == CntMax);
  assign leading   = ~cb_q[0];
  assign last_edge = (cb_q == LastEdge);

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == StIdle || cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    sr_tx_d = sr_tx_q;
    sr_rx_d = sr_rx_q;
    do_d    = do_q;
    load_d  = load_q;
    cb_d    = cb_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped.
        if (st && !done_q) begin
          cpha_d  = mode[0];
          lsb_d   = lsb_in;
          sclk_d  = mode[1];
          load_d  = load_dec;
          busy_d  = 1'b1;
          sr_rx_d = '0;
          state_d = StLead;
          if (!mode[0]) begin
            mosi_d  = tx_bit(DI, lsb_in);
            sr_tx_d = tx_shift(DI, lsb_in);
          end else begin
            sr_tx_d = DI;
          end
        end
      end
      StLead: begin
        if (ce_tact) state_d = StShift;
      end
      StShift: begin
        if (ce_tact) begin
          sclk_d = ~sclk_q;
          cb_d   = cb_q + 8'd1;
          if (leading == cpha_q) begin
            if (!last_edge) begin
              mosi_d  = tx_bit(sr_tx_q, lsb_q);
              sr_tx_d = tx_shift(sr_tx_q, lsb_q);
            end
          end else begin
            sr_rx_d = rx_shift(sr_rx_q, spi.MISO, lsb_q);
          end
          if (last_edge) state_d = StTrail;
        end
      end
      StTrail: begin
        if (ce_tact) begin
          load_d  = '1;
          do_d    = sr_rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cb_d    = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_tx_q <= '0;
      sr_rx_q <= '0;
      do_q    <= '0;
      load_q  <= '1;
      cb_q    <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_tx_q <= sr_tx_d;
      sr_rx_q <= sr_rx_d;
      do_q    <= do_d;
      load_q  <= load_d;
      cb_q    <= cb_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign spi.LOAD = load_q;
  assign spi.SCLK = sclk_q;
  assign spi.MOSI = mosi_q;
  assign DO       = do_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cb_bit   = cb_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param (M=9, DIV=4, NCS=2) with loopback and mode-0 slave models.
module tb_spi_master_param;
  localparam int unsigned M = 9, DIV = 4, NCS = 2;
  localparam int LAT = 1 + (2 * M + 2) * DIV;

  typedef struct {
    logic [M-1:0] dout;
    int           cyc;
  } exp_t;

  logic clk = 1'b0, clr = 1'b0, st = 1'b0;
  logic [M-1:0] DI = '0, DO;
  logic [1:0] mode = 2'd0;
  logic [2:0] cs = 3'd0;
  logic busy, done, ce_tact;
  logic [7:0] cb_bit;
`ifdef SPI_LSB_FIRST_EN
  logic lsb_first = 1'b0;
`endif

  spi_master_param_if #(.NCS(NCS)) spi ();

  spi_master_param #(.M(M), .DIV(DIV), .NCS(NCS)) dut (
    .clk     (clk),
    .clr     (clr),
    .st      (st),
    .DI      (DI),
    .mode    (mode),
    .cs      (cs),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .spi     (spi.master),
    .DO      (DO),
    .busy    (busy),
    .done    (done),
    .ce_tact (ce_tact),
    .cb_bit  (cb_bit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: loopback, or a mode-0 shifter presenting slave_word MSB first.
  logic         loopback = 1'b1;
  logic [M-1:0] slave_word = '0;
  logic         slave_miso = 1'b0;
  int           slave_idx = 0;
  logic [NCS-1:0] load_prev = '1;
  logic         sclk_prev_s = 1'b0;
  assign spi.MISO = loopback ? spi.MOSI : slave_miso;

  always @(negedge clk) begin
    if (load_prev == '1 && spi.LOAD != '1) begin
      slave_miso = slave_word[M-1];
      slave_idx  = M - 2;
    end else if (spi.LOAD != '1 && sclk_prev_s && !spi.SCLK && slave_idx >= 0) begin
      slave_miso = slave_word[slave_idx];
      slave_idx  = slave_idx - 1;
    end
    load_prev   = spi.LOAD;
    sclk_prev_s = spi.SCLK;
  end

  // Bus monitor: SCLK edge counts, MOSI captured on rising SCLK, LOAD checked while busy.
  logic [NCS-1:0] exp_load = '1;
  int   tog = 0, rise = 0, fall = 0, load_err = 0;
  logic [M-1:0] cap = '0;
  logic sclk_prev = 1'b0, first_fall = 1'b0;
  always @(negedge clk) begin
    if (spi.SCLK !== sclk_prev && cb_bit != 8'd0) begin
      tog++;
      if (cb_bit == 8'd1) first_fall = !spi.SCLK;
      if (spi.SCLK) begin
        rise++;
        cap = {cap[M-2:0], spi.MOSI};
      end else begin
        fall++;
      end
    end
    if (busy && spi.LOAD !== exp_load) load_err++;
    sclk_prev = spi.SCLK;
  end

  // Scoreboard monitor.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse_width", 32'(done_prev), 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with no frame pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("DO", 32'(DO), 32'(e.dout));
        chk("latency", 32'(cyc - e.cyc), 32'(LAT));
      end
    end
    done_prev = done;
  end

  task automatic frame(input logic [M-1:0] di, input logic [1:0] md, input logic [2:0] c,
                       input logic [M-1:0] expdo);
    exp_t e;
    @(negedge clk);
    DI = di; mode = md; cs = c; st = 1'b1;
    e.dout = expdo; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    st = 1'b0;
  endtask

  int t0, r0, f0, l0, k;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_LOAD", 32'(spi.LOAD), 32'h3);
    chk("rst_SCLK", 32'(spi.SCLK), 32'h0);
    chk("rst_MOSI", 32'(spi.MOSI), 32'h0);
    chk("rst_DO", 32'(DO), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ce_tact", 32'(ce_tact), 32'h0);
    chk("rst_cb_bit", 32'(cb_bit), 32'h0);
    clr = 1'b1;

    // Mode 0, slave returns 0F3.
    loopback = 1'b0; slave_word = 9'h0F3; exp_load = 2'b10;
    l0 = load_err; r0 = rise;
    frame(9'h1A5, 2'd0, 3'd0, 9'h0F3);
    repeat (85) @(negedge clk);
    chk("m0_load_during", 32'(load_err - l0), 32'd0);
    chk("m0_mosi_seq", 32'(cap), 32'h1A5);
    chk("m0_rises", 32'(rise - r0), 32'd9);
    chk("m0_load_after", 32'(spi.LOAD), 32'h3);
    chk("m0_busy_after", 32'(busy), 32'h0);

    // Mode 3 loopback.
    loopback = 1'b1;
    r0 = rise; f0 = fall;
    frame(9'h0FF, 2'd3, 3'd0, 9'h0FF);
    repeat (85) @(negedge clk);
    chk("m3_sclk_idle", 32'(spi.SCLK), 32'h1);
    chk("m3_first_falling", 32'(first_fall), 32'h1);
    chk("m3_rises", 32'(rise - r0), 32'd9);
    chk("m3_falls", 32'(fall - f0), 32'd9);
    chk("m3_mosi_seq", 32'(cap), 32'h0FF);

    // st held high, DI changed mid-frame: second frame starts one cycle after done.
    exp_load = 2'b01;
    @(negedge clk);
    DI = 9'h0A5; mode = 2'd0; cs = 3'd1; st = 1'b1; k = cyc;
    sb.push_back('{dout: 9'h0A5, cyc: k});
    sb.push_back('{dout: 9'h05A, cyc: k + LAT + 1});
    repeat (20) @(negedge clk);
    DI = 9'h05A;
    repeat (80) @(negedge clk);
    st = 1'b0;
    chk("held_busy_frame2", 32'(busy), 32'h1);
    repeat (80) @(negedge clk);
    chk("held_busy_end", 32'(busy), 32'h0);
    chk("held_pending", 32'(sb.size()), 32'd0);

    // Out-of-range channel: no select, full dummy frame.
    exp_load = 2'b11;
    l0 = load_err; t0 = tog;
    frame(9'h000, 2'd0, 3'd5, 9'h000);
    repeat (85) @(negedge clk);
    chk("cs5_load", 32'(load_err - l0), 32'd0);
    chk("cs5_toggles", 32'(tog - t0), 32'd18);

    // Reset 30 cycles into a frame: abandoned without done.
    exp_load = 2'b10;
    @(negedge clk);
    DI = 9'h1A5; mode = 2'd0; cs = 3'd0; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (29) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("midrst_LOAD", 32'(spi.LOAD), 32'h3);
    chk("midrst_SCLK", 32'(spi.SCLK), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_DO", 32'(DO), 32'h0);
    chk("midrst_cb_bit", 32'(cb_bit), 32'h0);
    clr = 1'b1;
    repeat (100) @(negedge clk);
    frame(9'h13C, 2'd0, 3'd0, 9'h13C);
    repeat (85) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);

`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    frame(9'h001, 2'd0, 3'd0, 9'h001);
    repeat (85) @(negedge clk);
    chk("lsb_mosi_seq", 32'(cap), 32'h100);
    lsb_first = 1'b0;
`endif

    chk("sb_pending_end", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
